// File: rtl/fpga_pcpi_ctrl.sv
// fpga_pcpi_ctrl: PCPI front-end for the embedded fabric model.
// Decodes custom-0 instructions into configuration-chain shifts and gated
// fabric execution runs, and returns the fabric result on pcpi_rd.
// Optional feature macro: FPGA_PCPI_STATUS_EN (enables funct7=4 STATUS readback).
module fpga_pcpi_ctrl #(
  parameter int CFG_HEIGHT  = 64,
  parameter int CFG_COLS    = 16,
  parameter int LAT_W       = 4,
  parameter int LAT_DEFAULT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcpi_valid,
  input  logic [31:0]           pcpi_insn,
  input  logic [31:0]           pcpi_rs1,
  input  logic [31:0]           pcpi_rs2,
  output logic                  pcpi_wr,
  output logic                  pcpi_wait,
  output logic                  pcpi_ready,
  output logic [31:0]           pcpi_rd,
  output logic                  fab_shift,
  output logic [CFG_HEIGHT-1:0] fab_cdata,
  output logic                  fab_en,
  output logic [31:0]           fab_in_a,
  output logic [31:0]           fab_in_b,
  input  logic [31:0]           fab_out,
  output logic                  cfg_done,
  output logic                  err
);

  localparam int WORDS  = CFG_HEIGHT / 32;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CCNT_W = $clog2(CFG_COLS + 1);

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F_PUSH      = 7'd0;
  localparam logic [6:0] F_CLEAR     = 7'd1;
  localparam logic [6:0] F_EXEC      = 7'd2;
  localparam logic [6:0] F_SETLAT    = 7'd3;
`ifdef FPGA_PCPI_STATUS_EN
  localparam logic [6:0] F_STATUS    = 7'd4;
`endif

  // PUSH is the single-cycle op state shared by CFG_PUSH, CFG_CLEAR and SET_LAT:
  // their register updates all happen at acceptance.
  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_EXEC, S_CAPT, S_STAT, S_RESP, S_COOL
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CCNT_W-1:0] ccnt_q;
  logic              cfg_done_q;
  logic              err_q;
  logic              shift_q;
  logic              wr_q;
  logic [LAT_W-1:0]  lat_q;
  logic [LAT_W-1:0]  cnt_q;
  logic [31:0]       a_q, b_q, rd_q;

  logic [6:0] funct7;
  logic       match;
  logic       accept;
  logic       push_wr;
  logic       clear_acc;
  logic       last_slot;
  logic       unused_insn;

  assign funct7      = pcpi_insn[31:25];
  assign unused_insn = ^pcpi_insn[24:7];

  // Instruction match: custom-0 opcode with a supported funct7
  always_comb begin
    match = 1'b0;
    if (pcpi_insn[6:0] == OPC_CUSTOM0) begin
      case (funct7)
        F_PUSH, F_CLEAR, F_EXEC, F_SETLAT: match = 1'b1;
`ifdef FPGA_PCPI_STATUS_EN
        F_STATUS:                          match = 1'b1;
`endif
        default:                           match = 1'b0;
      endcase
    end
  end

  assign accept    = (state_q == S_IDLE) && pcpi_valid && match;
  assign push_wr   = accept && (funct7 == F_PUSH) && !cfg_done_q;
  assign clear_acc = accept && (funct7 == F_CLEAR);
  assign last_slot = (wcnt_q == WCNT_W'(WORDS - 1));

  // Column assembly register, one 32-bit word per slot; word 0 is the LSBs
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_q;
      // Load this word when it is the push target; zero it on clear
      always_ff @(posedge clk) begin
        if (rst || clear_acc) begin
          word_q <= '0;
        end else if (push_wr && (wcnt_q == WCNT_W'(gi))) begin
          word_q <= pcpi_rs1;
        end
      end
      assign fab_cdata[gi*32 +: 32] = word_q;
    end
  endgenerate

`ifdef FPGA_PCPI_STATUS_EN
  logic [31:0] status_word;
  assign status_word = {err_q, cfg_done_q, 6'b0, 8'(ccnt_q), 8'(wcnt_q), 8'(lat_q)};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and PCPI/fabric handshake outputs
  always_comb begin
    state_d    = state_q;
    pcpi_ready = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    fab_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (funct7)
            F_EXEC:   state_d = cfg_done_q ? S_EXEC : S_RESP;
`ifdef FPGA_PCPI_STATUS_EN
            F_STATUS: state_d = S_STAT;
`endif
            default:  state_d = S_PUSH;
          endcase
        end
      end
      S_PUSH: begin
        pcpi_wait = 1'b1;
        state_d   = S_RESP;
      end
      S_EXEC: begin
        pcpi_wait = 1'b1;
        fab_en    = 1'b1;
        if (cnt_q == '0) state_d = S_CAPT;
      end
      S_CAPT: begin
        pcpi_wait = 1'b1;
        state_d   = S_RESP;
      end
      S_STAT: begin
        pcpi_wait = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = wr_q;
        pcpi_rd    = wr_q ? rd_q : 32'h0;
        state_d    = S_COOL;
      end
      S_COOL: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config counters, latency, operand/result registers, updated at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q     <= '0;
      ccnt_q     <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
      shift_q    <= 1'b0;
      wr_q       <= 1'b0;
      lat_q      <= LAT_W'(LAT_DEFAULT);
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
    end else begin
      shift_q <= 1'b0;
      if (accept) begin
        wr_q <= 1'b0;
        case (funct7)
          F_PUSH: begin
            if (cfg_done_q) begin
              err_q <= 1'b1;
            end else if (last_slot) begin
              wcnt_q  <= '0;
              ccnt_q  <= ccnt_q + 1'b1;
              shift_q <= 1'b1;
              if (ccnt_q == CCNT_W'(CFG_COLS - 1)) cfg_done_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
          F_CLEAR: begin
            wcnt_q     <= '0;
            ccnt_q     <= '0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
          end
          F_EXEC: begin
            if (!cfg_done_q) begin
              err_q <= 1'b1;
            end else begin
              a_q   <= pcpi_rs1;
              b_q   <= pcpi_rs2;
              // Latency 0 runs as 1 cycle
              cnt_q <= (lat_q == '0) ? '0 : lat_q - 1'b1;
            end
          end
          F_SETLAT: begin
            lat_q <= pcpi_rs1[LAT_W-1:0];
          end
          default: ;
        endcase
      end
      if ((state_q == S_EXEC) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
      if (state_q == S_CAPT) begin
        rd_q <= fab_out;
        wr_q <= 1'b1;
      end
`ifdef FPGA_PCPI_STATUS_EN
      if (state_q == S_STAT) begin
        rd_q <= status_word;
        wr_q <= 1'b1;
      end
`endif
    end
  end

  assign fab_shift = shift_q;
  assign fab_in_a  = a_q;
  assign fab_in_b  = b_q;
  assign cfg_done  = cfg_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fpga_pcpi_ctrl.sv
// Self-checking bench for fpga_pcpi_ctrl (default parameters).
`timescale 1ns/1ps
module tb_fpga_pcpi_ctrl;

  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        fab_shift;
  logic [63:0] fab_cdata;
  logic        fab_en;
  logic [31:0] fab_in_a, fab_in_b, fab_out;
  logic        cfg_done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_pcpi_ctrl dut (
    .clk(clk), .rst(rst), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .pcpi_rd(pcpi_rd),
    .fab_shift(fab_shift), .fab_cdata(fab_cdata), .fab_en(fab_en),
    .fab_in_a(fab_in_a), .fab_in_b(fab_in_b), .fab_out(fab_out),
    .cfg_done(cfg_done), .err(err)
  );

  // Fabric stand-in: a single register stage computing a^b while enabled
  always @(posedge clk) begin
    if (rst) fab_out <= 32'h0;
    else if (fab_en) fab_out <= fab_in_a ^ fab_in_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // fab_en and fab_shift must never coincide
  always @(negedge clk) begin
    if (fab_en || fab_shift) chk("en_shift_overlap", 64'(fab_en & fab_shift), 64'h0);
  end

  typedef struct {
    int          lat;
    logic        wr;
    logic [31:0] rd;
    int          en;
    int          sh;
    logic [63:0] cd;
    logic        err;
    logic        done;
  } exp_t;

  typedef struct {
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  // Reference model: pending words of the current column, column count, flags
  logic [31:0] m_q[$];
  int          m_cols;
  bit          m_done, m_err;
  int          m_lat;

  task automatic model_reset();
    m_q.delete();
    m_cols = 0;
    m_done = 0;
    m_err  = 0;
    m_lat  = 5;
  endtask

  task automatic model_op(input logic [6:0] f7, input logic [31:0] rs1,
                          input logic [31:0] rs2, output exp_t e);
    int l;
    e.lat = 2; e.wr = 0; e.rd = 0; e.en = 0; e.sh = 0; e.cd = 0;
    case (f7)
      7'd0: begin
        if (m_done) m_err = 1;
        else begin
          m_q.push_back(rs1);
          if (m_q.size() == 2) begin
            e.sh = 1;
            e.cd = {m_q[1], m_q[0]};
            m_q.delete();
            m_cols++;
            if (m_cols == 16) m_done = 1;
          end
        end
      end
      7'd1: begin
        m_q.delete(); m_cols = 0; m_done = 0; m_err = 0;
      end
      7'd2: begin
        if (!m_done) begin
          e.lat = 1;
          m_err = 1;
        end else begin
          l = (m_lat == 0) ? 1 : m_lat;
          e.lat = l + 2;
          e.en  = l;
          e.wr  = 1;
          e.rd  = rs1 ^ rs2;
        end
      end
      7'd3: m_lat = int'(rs1[3:0]);
      default: begin
        e.wr = 1;
        e.rd = {m_err, m_done, 6'b0, 8'(m_cols), 8'(m_q.size()), 8'(m_lat)};
      end
    endcase
    e.err  = m_err;
    e.done = m_done;
  endtask

  // Issue one matched instruction (called at a negedge with the DUT idle) and
  // compare the whole transaction; returns at a negedge with the DUT idle again.
  task automatic run_op(input string name, input logic [6:0] f7, input logic [31:0] rs1,
                        input logic [31:0] rs2, input exp_t e, input bit hold);
    int          lat = 0, en_n = 0, sh_n = 0, wait_n = 0, extra = 0;
    logic        wr_s = 0, err_s = 0, done_s = 0;
    logic [31:0] rd_s = 0;
    logic [63:0] cd_s = 0;
    pcpi_valid = 1'b1;
    pcpi_insn  = {f7, 18'h0, OPC};
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    @(negedge clk);
    if (!hold) pcpi_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (fab_en) en_n++;
      if (fab_shift) begin sh_n++; cd_s = fab_cdata; end
      if (pcpi_ready) begin
        lat = k; wr_s = pcpi_wr; rd_s = pcpi_rd; err_s = err; done_s = cfg_done;
        break;
      end
      if (pcpi_wait) wait_n++;
      @(negedge clk);
    end
    $display("op %s f7=%0d rs1=%h rs2=%h lat=%0d wr=%0d rd=%h en=%0d sh=%0d",
             name, f7, rs1, rs2, lat, wr_s, rd_s, en_n, sh_n);
    chk({name, " ready_latency"}, 64'(lat), 64'(e.lat));
    chk({name, " wr"}, 64'(wr_s), 64'(e.wr));
    chk({name, " rd"}, 64'(rd_s), 64'(e.rd));
    chk({name, " fab_en_cycles"}, 64'(en_n), 64'(e.en));
    chk({name, " shifts"}, 64'(sh_n), 64'(e.sh));
    if (e.sh != 0) chk({name, " cdata"}, cd_s, e.cd);
    chk({name, " wait_cycles"}, 64'(wait_n), 64'((e.lat > 1) ? e.lat - 1 : 0));
    chk({name, " err"}, 64'(err_s), 64'(e.err));
    chk({name, " cfg_done"}, 64'(done_s), 64'(e.done));
    @(negedge clk);  // COOL
    chk({name, " cool_ready_wait"}, 64'({pcpi_ready, pcpi_wait}), 64'h0);
    @(negedge clk);  // IDLE
    if (hold) begin
      pcpi_valid = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (pcpi_ready || pcpi_wait) extra++;
      end
      chk({name, " held_valid_not_reaccepted"}, 64'(extra), 64'h0);
    end
  endtask

  task automatic model_run(input string name, input logic [6:0] f7,
                           input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    model_op(f7, rs1, rs2, e);
    run_op(name, f7, rs1, rs2, e, 1'b0);
  endtask

  // Unmatched instruction held valid for 10 cycles: no wait, no ready
  task automatic no_resp(input string name, input logic [31:0] insn);
    int r = 0, w = 0;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    repeat (10) begin
      @(negedge clk);
      if (pcpi_ready) r++;
      if (pcpi_wait) w++;
    end
    pcpi_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pcpi_ready) r++;
      if (pcpi_wait) w++;
    end
    $display("unmatched %s insn=%h ready_cycles=%0d wait_cycles=%0d", name, insn, r, w);
    chk({name, " ready"}, 64'(r), 64'h0);
    chk({name, " wait"}, 64'(w), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    exp_t e, dummy;
    int   rdy_n, en_n, sel;
    logic [6:0] f7;

    vecs[0] = '{7'd2, 32'h1, 32'h2,
                '{1, 1'b0, 32'h0, 0, 0, 64'h0, 1'b1, 1'b0}};           // EXEC before config
    vecs[1] = '{7'd1, 32'h0, 32'h0,
                '{2, 1'b0, 32'h0, 0, 0, 64'h0, 1'b0, 1'b0}};           // CLEAR
    vecs[2] = '{7'd0, 32'h11111111, 32'h0,
                '{2, 1'b0, 32'h0, 0, 0, 64'h0, 1'b0, 1'b0}};           // PUSH word 0
    vecs[3] = '{7'd0, 32'h22222222, 32'h0,
                '{2, 1'b0, 32'h0, 0, 1, 64'h2222222211111111, 1'b0, 1'b0}}; // PUSH word 1
    vecs[4] = '{7'd3, 32'h7, 32'h0,
                '{2, 1'b0, 32'h0, 0, 0, 64'h0, 1'b0, 1'b0}};           // SET_LAT 7

    rst = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn = 32'h0;
    pcpi_rs1 = 32'h0;
    pcpi_rs2 = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset handshake", 64'({pcpi_ready, pcpi_wait, pcpi_wr}), 64'h0);
    chk("reset rd", 64'(pcpi_rd), 64'h0);
    chk("reset fabric ctl", 64'({fab_shift, fab_en, cfg_done, err}), 64'h0);
    chk("reset cdata", fab_cdata, 64'h0);
    chk("reset operands", {fab_in_a, fab_in_b}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      model_op(vecs[i].f7, vecs[i].rs1, vecs[i].rs2, dummy);
      run_op($sformatf("vec%0d", i), vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].e, 1'b0);
    end

    // Fill remaining 15 columns
    for (int i = 0; i < 30; i++) model_run("fill_push", 7'd0, $urandom, 32'h0);
    chk("cfg_done after fill", 64'(cfg_done), 64'h1);
    model_run("extra_push", 7'd0, 32'hcafef00d, 32'h0);
    chk("err after extra push", 64'(err), 64'h1);

    // SET_LAT 5 with valid held through RESP and COOL
    model_op(7'd3, 32'h5, 32'h0, e);
    run_op("setlat5_hold", 7'd3, 32'h5, 32'h0, e, 1'b1);

    // EXEC with L=5
    model_op(7'd2, 32'hffff0000, 32'h55555555, dummy);
    e = '{7, 1'b1, 32'haaaa5555, 5, 0, 64'h0, 1'b1, 1'b1};
    run_op("exec_l5", 7'd2, 32'hffff0000, 32'h55555555, e, 1'b0);

    // SET_LAT 0 then EXEC: one fabric cycle
    model_run("setlat0", 7'd3, 32'h0, 32'h0);
    model_op(7'd2, 32'h12345678, 32'h0000ffff, dummy);
    e = '{3, 1'b1, 32'h1234a987, 1, 0, 64'h0, 1'b1, 1'b1};
    run_op("exec_l0", 7'd2, 32'h12345678, 32'h0000ffff, e, 1'b0);
    model_run("setlat5", 7'd3, 32'h5, 32'h0);

    // Reset during cycle T+3 of an EXEC
    pcpi_valid = 1'b1;
    pcpi_insn  = {7'd2, 18'h0, OPC};
    pcpi_rs1   = 32'hdead0000;
    pcpi_rs2   = 32'h0000beef;
    @(negedge clk);                                  // T+1
    pcpi_valid = 1'b0;
    rdy_n = 0; en_n = 0;
    for (int k = 1; k <= 3; k++) begin
      if (pcpi_ready) rdy_n++;
      if (fab_en) en_n++;
      if (k < 3) @(negedge clk);
    end
    rst = 1'b1;                                      // T+3
    @(negedge clk);                                  // T+4
    rst = 1'b0;
    $display("midrun_reset en_before=%0d fab_en=%0d cfg_done=%0d err=%0d wait=%0d",
             en_n, fab_en, cfg_done, err, pcpi_wait);
    chk("midrun en before reset", 64'(en_n), 64'h3);
    chk("midrun post-reset flags", 64'({fab_en, cfg_done, err, pcpi_wait, pcpi_ready}), 64'h0);
    chk("midrun post-reset operands", {fab_in_a, fab_in_b}, 64'h0);
    repeat (10) begin
      @(negedge clk);
      if (pcpi_ready) rdy_n++;
    end
    chk("midrun no ready", 64'(rdy_n), 64'h0);
    model_reset();

`ifdef FPGA_PCPI_STATUS_EN
    model_op(7'd4, 32'h0, 32'h0, e);
    run_op("status_after_reset", 7'd4, 32'h0, 32'h0, e, 1'b0);
    chk("status latency field", 64'(e.rd), 64'h5);
`else
    no_resp("funct7_4_unmatched", {7'd4, 18'h0, OPC});
`endif
    no_resp("opcode_0110011", {7'd2, 18'h0, 7'b0110011});
    no_resp("funct7_9", {7'd9, 18'h0, OPC});

    // Reconfigure; EXEC then runs with the post-reset default latency
    for (int i = 0; i < 32; i++) model_run("refill_push", 7'd0, $urandom, 32'h0);
    model_run("exec_default_lat", 7'd2, $urandom, $urandom);

    // Randomized mix against the model
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 65) f7 = 7'd0;
      else if (sel < 80) f7 = 7'd2;
      else if (sel < 93) f7 = 7'd3;
      else if (sel < 95) f7 = 7'd1;
      else begin
`ifdef FPGA_PCPI_STATUS_EN
        f7 = 7'd4;
`else
        f7 = 7'd2;
`endif
      end
      model_run("rand", f7, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_pcpi_ctrl.md
# fpga_pcpi_ctrl

Parametrised PCPI front-end for the embedded fabric model. It sits between the PicoRV32 PCPI port and the `fpga` fabric. It turns custom-0 instructions into configuration-chain shifts (`fab_shift`/`fab_cdata`) and gated fabric execution runs, and it returns the fabric result on `pcpi_rd`. This moves bitstream loading and the fixed clock-count execution, both currently driven by benches, into RTL that the core can drive itself.

## Interface
Parameters:
- `CFG_HEIGHT`, 64: config column width in bits; must be a multiple of 32 and ≥32.
- `CFG_COLS`, 16: number of columns in a full bitstream.
- `LAT_W`, 4: width of the execution-latency register.
- `LAT_DEFAULT`, 5: latency after reset, in fabric cycles.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pcpi_valid` in 1: the core presents an instruction.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1` in 32: operand 1.
- `pcpi_rs2` in 32: operand 2.
- `pcpi_wr` out 1: write `pcpi_rd` back to rd; valid with `pcpi_ready`.
- `pcpi_wait` out 1: recognised instruction in progress.
- `pcpi_ready` out 1: one-cycle completion pulse.
- `pcpi_rd` out 32: result.
- `fab_shift` out 1: one-cycle config-chain shift strobe.
- `fab_cdata` out CFG_HEIGHT: column data; stable while `fab_shift` is high.
- `fab_en` out 1: fabric clock enable.
- `fab_in_a` out 32: fabric operand A.
- `fab_in_b` out 32: fabric operand B.
- `fab_out` in 32: fabric result.
- `cfg_done` out 1: all CFG_COLS columns have been shifted.
- `err` out 1: sticky error flag.

## Operation
- Match condition: `pcpi_insn[6:0]==7'b0001011` and funct7 = `pcpi_insn[31:25]` is a supported opcode. Any other instruction gets no response, and `pcpi_wait`/`pcpi_ready` stay 0.
- State machine:
  - IDLE: on valid&match, latch rs1, rs2 and funct7, then go to the op state.
  - PUSH: 1 cycle, then RESP.
  - EXEC: L cycles, then CAPT.
  - CAPT: 1 cycle, then RESP.
  - RESP: `pcpi_ready`=1, then COOL.
  - COOL: 1 cycle, ignores valid, then IDLE.
- funct7=0, CFG_PUSH:
  - rs1 is written to word slot `wcnt` of the assembly register (word 0 = bits [31:0]), then `wcnt` increments.
  - When the slot is CFG_HEIGHT/32−1, PUSH asserts `fab_shift` with the completed column, `wcnt` becomes 0 and `ccnt` increments. `ccnt==CFG_COLS` sets `cfg_done`.
  - If `cfg_done` is already set: no shift, `err`←1.
  - Response: `pcpi_wr`=0.
- funct7=1, CFG_CLEAR: `wcnt`, `ccnt`, `cfg_done` and `err` go to 0; the assembly register is zeroed. Response: `pcpi_wr`=0.
- funct7=2, EXEC:
  - If `cfg_done`=0: go straight to RESP with `pcpi_wr`=0 and set `err`.
  - Otherwise `fab_in_a`/`fab_in_b` hold rs1/rs2 from the cycle after acceptance until RESP, and `fab_en`=1 for exactly L cycles.
  - CAPT registers `fab_out` into `pcpi_rd`. Response: `pcpi_wr`=1.
- funct7=3, SET_LAT: latency ← `rs1[LAT_W-1:0]`. Effective L = max(latency, 1). Response: `pcpi_wr`=0.
- `pcpi_wait`=1 in every non-IDLE state except RESP and COOL.
- `pcpi_rd`=0 whenever `pcpi_wr`=0.

## Timing
- Acceptance cycle T (IDLE, valid&match). The remaining offsets are all relative to T:
  - PUSH/CLEAR/SET_LAT: `pcpi_ready` at T+2, `fab_shift` at T+1.
  - EXEC: `fab_en` during T+1..T+L, capture at T+L+1, `pcpi_ready` at T+L+2.
  - EXEC with `cfg_done`=0: `pcpi_ready` at T+1.
- A new instruction cannot be accepted before T_ready+2. Valid held high through COOL is not re-accepted.
- Reset, including mid-run: state←IDLE; all outputs ←0 (`fab_cdata`, `fab_in_a`, `fab_in_b` included); `cfg_done`=0, `err`=0; `wcnt`=`ccnt`=0; latency←LAT_DEFAULT. Any pending instruction is dropped with no `pcpi_ready`.
- `fab_en` is never high in the same cycle as `fab_shift`.

## Configuration
- `FPGA_PCPI_STATUS_EN` defined: funct7=4 (STATUS) is matched. It returns `{err, cfg_done, 6'b0, ccnt[7:0], wcnt[7:0], latency zero-extended to 8 bits}` with `pcpi_wr`=1 and `pcpi_ready` at T+2.
- Undefined: funct7=4 is unmatched and receives no response.

## Test plan
- Reset, then CFG_PUSH with CFG_HEIGHT=64: words 0x11111111 and 0x22222222 → a single `fab_shift` pulse with `fab_cdata`=0x2222222211111111, `wcnt`=0 and `pcpi_wr`=0 at each ready.
- Push CFG_COLS×2 words → `cfg_done`=1 after the last one; one extra push → no shift and `err`=1.
- Configured fabric acting as a register stage, L=5, EXEC with rs1=0xffff0000 and rs2=0x55555555 → `fab_en` high for exactly 5 cycles, `pcpi_ready` at T+7, `pcpi_rd` equal to `fab_out` at capture, `pcpi_wr`=1.
- SET_LAT with 0, then EXEC → `fab_en` high for exactly 1 cycle and `pcpi_ready` at T+3. EXEC before config → `pcpi_ready` at T+1, `pcpi_wr`=0, `err`=1.
- Assert `rst` for one cycle at T+3 of an EXEC → no `pcpi_ready`; `fab_en`, `cfg_done`, `err` and `pcpi_wait` are all 0 the next cycle; latency reads back 5 via STATUS (with FPGA_PCPI_STATUS_EN).
- Opcode 0110011 with valid held high for 10 cycles → `pcpi_wait` and `pcpi_ready` stay 0. Without the macro, funct7=4 behaves the same way.
